// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU's byte bus: 128 KiB RAM, UART RX/TX ports,
// cycle-counter snapshot and program-stop flag, with a small TX FIFO toward the UART.
module mem_io_responder #(
   parameter int ADDR_WIDTH    = 17,
   parameter int TX_FIFO_DEPTH = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] bus_addr,
   input  logic        bus_wr,
   input  logic [7:0]  bus_wdata,
   output logic [7:0]  bus_rdata,
   output logic        io_buffer_full,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halt,
   output logic        tx_overflow,
   output logic [31:0] cycle_count
);
   localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TX_FIFO_DEPTH);
   localparam logic [CNT_W-1:0] NEAR_CNT = CNT_W'(TX_FIFO_DEPTH - 2);

   logic [7:0]            mem_q [2**ADDR_WIDTH];
   logic [7:0]            ram_rd_q;
   logic [7:0]            fifo_q [TX_FIFO_DEPTH];

   logic                  src_ram_q, src_ram_d;
   logic [7:0]            io_rd_q, io_rd_d;
   logic                  rx_pop_q, rx_pop_d;
   logic [31:0]           snap_q, snap_d;
   logic [31:0]           cycle_q, cycle_d;
   logic                  halt_q, halt_d;
   logic                  ovf_q, ovf_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  io_sel, io_rx_sel, io_cnt_sel, io_halt_sel;
   logic                  ram_we, ram_re;
   logic                  push, push_ok, pop;
   logic [7:0]            push_byte;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  unused_addr;

   assign unused_addr = ^bus_addr[31:18];
   assign ram_addr    = bus_addr[ADDR_WIDTH-1:0];
   assign io_sel      = (bus_addr[17:16] == 2'b11);
   assign io_rx_sel   = io_sel && (bus_addr[15:0] == 16'h0000);
   assign io_cnt_sel  = io_sel && (bus_addr[15:2] == 14'h0001);
   assign io_halt_sel = io_sel && (bus_addr[15:0] == 16'h0004);
   assign ram_we      = !io_sel && bus_wr && !rst_in;
   assign ram_re      = !io_sel && !bus_wr;

   // RAM has no reset so it can map onto block RAM; read port has an enable so writes hold the old byte
   always_ff @(posedge clk_in) begin
      if (ram_we) mem_q[ram_addr] <= bus_wdata;
      if (ram_re) ram_rd_q <= mem_q[ram_addr];
   end

   always_ff @(posedge clk_in) begin
      if (push_ok && !rst_in) fifo_q[wr_ptr_q] <= push_byte;
   end

   always_comb begin
      src_ram_d = src_ram_q;
      io_rd_d   = io_rd_q;
      rx_pop_d  = 1'b0;
      snap_d    = snap_q;
      if (!bus_wr) begin
         if (!io_sel) begin
            src_ram_d = 1'b1;
         end else begin
            src_ram_d = 1'b0;
            io_rd_d   = 8'h00;
            if (io_rx_sel) begin
               if (rx_valid) begin
                  io_rd_d  = rx_data;
                  rx_pop_d = 1'b1;
               end
            end else if (io_cnt_sel) begin
               case (bus_addr[1:0])
                  2'd0: begin
                     snap_d  = cycle_q;
                     io_rd_d = cycle_q[7:0];
                  end
                  2'd1: io_rd_d = snap_q[15:8];
                  2'd2: io_rd_d = snap_q[23:16];
                  default: io_rd_d = snap_q[31:24];
               endcase
            end
         end
      end
   end

   always_comb begin
      push      = bus_wr && ((io_rx_sel && (bus_wdata != 8'h00)) || io_halt_sel);
      push_byte = io_halt_sel ? 8'h00 : bus_wdata;
      push_ok   = push && (cnt_q != FULL_CNT);
      pop       = (cnt_q != '0) && tx_ready;
      wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      cnt_d     = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
      ovf_d     = ovf_q | (push && !push_ok);
      halt_d    = halt_q | (bus_wr && io_halt_sel);
      cycle_d   = cycle_q + 32'd1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         src_ram_q <= 1'b0;
         io_rd_q   <= 8'h00;
         rx_pop_q  <= 1'b0;
         snap_q    <= 32'h0;
         cycle_q   <= 32'h0;
         halt_q    <= 1'b0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         src_ram_q <= src_ram_d;
         io_rd_q   <= io_rd_d;
         rx_pop_q  <= rx_pop_d;
         snap_q    <= snap_d;
         cycle_q   <= cycle_d;
         halt_q    <= halt_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus_rdata      = src_ram_q ? ram_rd_q : io_rd_q;
   assign rx_pop         = rx_pop_q;
   assign tx_valid       = (cnt_q != '0);
   assign tx_data        = fifo_q[rd_ptr_q];
   assign io_buffer_full = (cnt_q >= NEAR_CNT);
   assign halt           = halt_q;
   assign tx_overflow    = ovf_q;
   assign cycle_count    = cycle_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: directed bus transactions push expected
// read bytes and TX bytes into queues; monitors pop and compare as the DUT presents them.
module tb_mem_io_responder;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [31:0] bus_addr = '0;
   logic        bus_wr = 1'b0;
   logic [7:0]  bus_wdata = '0;
   logic [7:0]  bus_rdata;
   logic        io_buffer_full;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_pop;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        halt;
   logic        tx_overflow;
   logic [31:0] cycle_count;

   int          n_checks = 0;
   int          n_fail = 0;
   logic        rd_tag = 1'b0;
   logic        pop_tag = 1'b0;
   logic [31:0] tb_cyc = '0;
   logic [7:0]  rd_exp [$];
   logic [7:0]  tx_exp [$];

   mem_io_responder #(.ADDR_WIDTH(17), .TX_FIFO_DEPTH(8)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .bus_addr(bus_addr), .bus_wr(bus_wr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .io_buffer_full(io_buffer_full),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .halt(halt), .tx_overflow(tx_overflow),
      .cycle_count(cycle_count)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) tb_cyc <= rst_in ? 32'h0 : tb_cyc + 32'd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // read-data / rx_pop monitor: one cycle after a tagged transaction
   initial begin : mon_rd
      logic due_rd, due_pop, in_rst;
      logic [7:0] e;
      forever begin
         @(posedge clk_in);
         due_rd  = rd_tag;
         due_pop = pop_tag;
         in_rst  = rst_in;
         @(negedge clk_in);
         if (due_rd) begin
            if (rd_exp.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rdata_queue: got 0x%0h expected nothing pending", bus_rdata);
            end else begin
               e = rd_exp.pop_front();
               check("bus_rdata", {24'h0, bus_rdata}, {24'h0, e});
            end
         end
         if (!in_rst) check("rx_pop", {31'h0, rx_pop}, {31'h0, due_pop});
      end
   end

   initial begin : mon_tx
      logic [7:0] e;
      forever begin
         @(negedge clk_in);
         if (!rst_in && tx_valid && tx_ready) begin
            if (tx_exp.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL tx_unexpected: got 0x%0h expected no TX byte", tx_data);
            end else begin
               e = tx_exp.pop_front();
               check("tx_data", {24'h0, tx_data}, {24'h0, e});
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic w, input logic [7:0] d,
                        input logic rt, input logic pt);
      bus_addr  = a;
      bus_wr    = w;
      bus_wdata = d;
      rd_tag    = rt;
      pop_tag   = pt;
      tick();
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [7:0] exp, input logic exp_pop);
      rd_exp.push_back(exp);
      drive(a, 1'b0, 8'h00, 1'b1, exp_pop);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
      drive(a, 1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic bus_write_hold(input logic [31:0] a, input logic [7:0] d, input logic [7:0] exp);
      rd_exp.push_back(exp);
      drive(a, 1'b1, d, 1'b1, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(32'h0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin : stim
      logic [7:0] bytes [8];
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

      idle(2);
      check("rst_rdata", {24'h0, bus_rdata}, 32'h0);
      check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_halt", {31'h0, halt}, 32'h0);
      check("rst_ovf", {31'h0, tx_overflow}, 32'h0);
      check("rst_cycle", cycle_count, 32'h0);
      check("rst_rx_pop", {31'h0, rx_pop}, 32'h0);
      rst_in = 1'b0;

      // RAM
      bus_write(32'h0000_0123, 8'hA5);
      bus_read(32'h0000_0123, 8'hA5, 1'b0);
      bus_write(32'h0001_FFFF, 8'h3C);
      bus_read(32'h0001_FFFF, 8'h3C, 1'b0);
      bus_write_hold(32'h0000_0200, 8'h77, 8'h3C);
      bus_read(32'h0000_0200, 8'h77, 1'b0);
      bus_read(32'h0003_0123, 8'h00, 1'b0);

      // TX with transmitter ready
      tx_ready = 1'b1;
      tx_exp.push_back(8'h48);
      bus_write(32'h0003_0000, 8'h48);
      tx_exp.push_back(8'h69);
      bus_write(32'h0003_0000, 8'h69);
      bus_write(32'h0003_0000, 8'h00);
      idle(4);
      check("tx_hi_drained", tx_exp.size(), 32'h0);
      check("tx_hi_valid", {31'h0, tx_valid}, 32'h0);

      // fill, near-full flag, overflow, drain
      tx_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tx_exp.push_back(bytes[k]);
         bus_write(32'h0003_0000, bytes[k]);
         check("io_full", {31'h0, io_buffer_full}, (k + 1 >= 6) ? 32'h1 : 32'h0);
      end
      check("ovf_before", {31'h0, tx_overflow}, 32'h0);
      bus_write(32'h0003_0000, 8'h99);
      check("ovf_after", {31'h0, tx_overflow}, 32'h1);
      check("io_full_ovf", {31'h0, io_buffer_full}, 32'h1);
      tx_ready = 1'b1;
      idle(10);
      check("fifo_drained", tx_exp.size(), 32'h0);
      check("fifo_valid", {31'h0, tx_valid}, 32'h0);
      check("io_full_empty", {31'h0, io_buffer_full}, 32'h0);

      // cycle-counter snapshot
      for (int i = 0; i < 400 && tb_cyc != 32'h105; i++) idle(1);
      check("cyc_reach", tb_cyc, 32'h105);
      check("cyc_model", cycle_count, tb_cyc);
      bus_read(32'h0003_0004, 8'h05, 1'b0);
      idle(3);
      bus_read(32'h0003_0005, 8'h01, 1'b0);
      bus_read(32'h0003_0006, 8'h00, 1'b0);
      bus_read(32'h0003_0007, 8'h00, 1'b0);

      // UART RX and unmapped I/O
      rx_valid = 1'b1;
      rx_data  = 8'h37;
      bus_read(32'h0003_0000, 8'h37, 1'b1);
      rx_valid = 1'b0;
      rx_data  = 8'h99;
      bus_read(32'h0003_0000, 8'h00, 1'b0);
      bus_read(32'h0003_0010, 8'h00, 1'b0);
      bus_write(32'h0003_0008, 8'h55);
      bus_write(32'h0003_0005, 8'h55);
      idle(2);
      check("halt_clear", {31'h0, halt}, 32'h0);

      // halt, then reset with bytes queued
      tx_ready = 1'b0;
      tx_exp.push_back(8'h00);
      bus_write(32'h0003_0004, 8'h5A);
      check("halt_set", {31'h0, halt}, 32'h1);
      tx_exp.push_back(8'h41);
      bus_write(32'h0003_0000, 8'h41);
      tx_exp.push_back(8'h42);
      bus_write(32'h0003_0000, 8'h42);
      check("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
      rst_in = 1'b1;
      bus_write(32'h0000_0123, 8'hEE);
      tx_exp.delete();
      check("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst2_halt", {31'h0, halt}, 32'h0);
      check("rst2_cycle", cycle_count, 32'h0);
      check("rst2_ovf", {31'h0, tx_overflow}, 32'h0);
      check("rst2_rdata", {24'h0, bus_rdata}, 32'h0);
      bus_write(32'h0003_0000, 8'h43);
      rst_in   = 1'b0;
      tx_ready = 1'b1;
      idle(4);
      check("post_rst_valid", {31'h0, tx_valid}, 32'h0);
      bus_read(32'h0000_0123, 8'hA5, 1'b0);
      idle(3);
      check("rd_queue_empty", rd_exp.size(), 32'h0);
      check("tx_queue_empty", tx_exp.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
